// File: rtl/dmem_arb_pkg.sv
// Shared definitions for dmem_arbiter: FSM state encoding, requester port indices
// and the lock-hold limit used when DMEM_ARB_LOCK_EN is defined.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int LOCK_LIMIT = 16;
  localparam int LOCK_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the port that was not granted last.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_win
);

  assign o_valid = |i_req;
  assign o_win   = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM, one access per
// three cycles (IDLE/ISSUE/RESP). Optional grant locking under DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_we;
  logic              r_win;
  logic              r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        w_req;
  logic              w_valid;
  logic              w_win;

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_LAST = LOCK_CNT_W'(LOCK_LIMIT - 1);

  logic                  r_locked;
  logic                  r_lock_port;
  logic [LOCK_CNT_W-1:0] r_lock_cnt;
  logic                  w_win_lock;

  assign w_win_lock = (r_win == PORT_DBG) ? lock1 : lock0;
  // While locked, the other port's request is hidden from the picker.
  assign w_req = !r_locked                 ? {req1, req0} :
                 (r_lock_port == PORT_DBG) ? {req1, 1'b0} : {1'b0, req0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_locked    <= 1'b0;
      r_lock_port <= PORT_CPU;
      r_lock_cnt  <= '0;
    end else if (r_state == ST_RESP) begin
      if (w_win_lock && (r_lock_cnt != LOCK_CNT_LAST)) begin
        r_locked    <= 1'b1;
        r_lock_port <= r_win;
        r_lock_cnt  <= r_lock_cnt + 1'b1;
      end else begin
        r_locked    <= 1'b0;
        r_lock_cnt  <= '0;
      end
    end
  end
`else
  assign w_req = {req1, req0};
`endif

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Winner's command is captured on the IDLE->ISSUE edge and held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we        <= 1'b0;
      r_win       <= PORT_CPU;
      r_last      <= PORT_DBG;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_valid) begin
        r_win       <= w_win;
        r_we        <= (w_win == PORT_DBG) ? we1    : we0;
        r_mem_addr  <= (w_win == PORT_DBG) ? addr1  : addr0;
        r_mem_wdata <= (w_win == PORT_DBG) ? wdata1 : wdata0;
      end
      if (r_state == ST_RESP) r_last <= r_win;
    end
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    rd_data = '0;
    case (r_state)
      ST_ISSUE: begin
        mem_en = 1'b1;
        mem_we = r_we;
      end
      ST_RESP: begin
        ack0 = (r_win == PORT_CPU);
        ack1 = (r_win == PORT_DBG);
        if (!r_we) rd_data = mem_rdata;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
